// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Multi-byte packets hold the transmitter until their last byte or a lock timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 1_000_000
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [8*NUM_REQ-1:0]   i_req_byte,
    input  logic [NUM_REQ-1:0]     i_req_last,
    output logic [NUM_REQ-1:0]     o_req_ready,
    output logic                   o_tx_dv,
    output logic [7:0]             o_tx_byte,
    input  logic                   i_tx_active,
    input  logic                   i_tx_done,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic                   o_busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W:0]   NUM_EXT  = (PTR_W+1)'(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        HOLD
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic               lock_n;
    logic [CNT_W-1:0]   hold_cnt;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic [PTR_W-1:0]   sel_idx;
    logic [7:0]         sel_byte;
    logic               sel_last;
    logic               xfer;

    // Scan rr_ptr+1, rr_ptr+2, ... (wrapping) and take the first valid requester.
    always_comb begin
        logic [PTR_W:0] sum;
        logic [PTR_W-1:0] cand;
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        sum        = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (sum >= NUM_EXT) begin
                sum = sum - NUM_EXT;
            end
            cand = sum[PTR_W-1:0];
            if (!win_found && i_req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        if (win_found) begin
            win_onehot[win_idx] = 1'b1;
        end
    end

    always_comb begin
        o_req_ready = '0;
        if (i_rst_n) begin
            case (state)
                IDLE:    o_req_ready = win_onehot;
                HOLD:    o_req_ready = o_grant;
                default: o_req_ready = '0;
            endcase
        end
    end

    // While a packet is locked, rr_ptr already names the owner.
    assign sel_idx  = (state == IDLE) ? win_idx : rr_ptr;
    assign sel_byte = i_req_byte[{sel_idx, 3'b000} +: 8];
    assign sel_last = i_req_last[sel_idx];
    assign xfer     = |(o_req_ready & i_req_valid);

    // The start pulse follows the transmitter's busy flag in the same cycle,
    // which is what gives a one-cycle transfer-to-pulse latency.
    assign o_tx_dv = (state == ISSUE) && !i_tx_active;
    assign o_busy  = (state != IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            o_tx_byte <= 8'h00;
            o_grant   <= '0;
            rr_ptr    <= PTR_INIT;
            lock_n    <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        o_tx_byte <= sel_byte;
                        lock_n    <= !sel_last;
                        o_grant   <= win_onehot;
                        rr_ptr    <= win_idx;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!i_tx_active) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (i_tx_done) begin
                        if (lock_n) begin
                            hold_cnt <= '0;
                            state    <= HOLD;
                        end else begin
                            o_grant <= '0;
                            state   <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (xfer) begin
                        o_tx_byte <= sel_byte;
                        lock_n    <= !sel_last;
                        state     <= ISSUE;
                    end else if (hold_cnt == CNT_LAST) begin
                        o_grant <= '0;
                        lock_n  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Structural invariants of the handshake and grant.
    a_ready_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(o_req_ready));
    a_grant_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(o_grant));
    a_dv_single: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        o_tx_dv |=> !o_tx_dv);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised and directed bench for uart_tx_arbiter: a transaction-level model
// predicts handshakes, and a scoreboard checks every start pulse.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int LOCK_TIMEOUT = 16;

    logic                 clk;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_byte;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_dv;
    logic [7:0]           tx_byte;
    logic                 tx_active;
    logic                 tx_done;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;

    logic                 frame_active;
    logic                 ext_busy;
    bit                   spurious_en;
    bit [NUM_REQ-1:0]     paused;

    int checks = 0;
    int errors = 0;

    // Per-requester pending bytes, {last, data}.
    logic [8:0] rq [NUM_REQ][$];

    typedef struct {
        logic [7:0] data;
        int         idx;
    } sb_t;
    sb_t        sb [$];
    logic [7:0] tx_log [$];

    // Reference model: who owns the transmitter and what it is doing.
    int         m_last;
    int         m_owner;
    int         m_age;
    bit         m_pending;
    bit         m_issued;
    bit         m_locked;
    logic [7:0] m_byte;

    assign tx_active = frame_active | ext_busy;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_byte  (req_byte),
        .i_req_last  (req_last),
        .o_req_ready (req_ready),
        .o_tx_dv     (tx_dv),
        .o_tx_byte   (tx_byte),
        .i_tx_active (tx_active),
        .i_tx_done   (tx_done),
        .o_grant     (grant),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic failBound(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=timeout expected=completion at %0t", name, $time);
    endtask

    task automatic applyStimulus(input int req, input logic [7:0] data, input bit last);
        rq[req].push_back({last, data});
    endtask

    task automatic nextCycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    function automatic bit tbIdle();
        int pending_bytes = 0;
        for (int i = 0; i < NUM_REQ; i++) pending_bytes += rq[i].size();
        return !m_pending && !m_issued && !m_locked && (pending_bytes == 0);
    endfunction

    task automatic waitIdle(input string name, input int budget);
        int n = 0;
        while (!tbIdle() && n < budget) begin
            nextCycle(1);
            n++;
        end
        if (!tbIdle()) failBound(name);
        nextCycle(2);
    endtask

    task automatic expectLog(input string name, input int n,
                             input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
        logic [7:0] exp_b [6];
        exp_b = '{b0, b1, b2, b3, b4, b5};
        checkOutput($sformatf("%s_count", name), 32'(tx_log.size()), 32'(n));
        for (int i = 0; i < n && i < tx_log.size(); i++) begin
            checkOutput($sformatf("%s_byte%0d", name, i), 32'(tx_log[i]), 32'(exp_b[i]));
        end
    endtask

    // Requesters: present the head of each queue, pop it on an accepted handshake.
    initial begin : driver
        logic [NUM_REQ-1:0] seen;
        logic [8:0]         head;
        req_valid = '0;
        req_byte  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            seen = req_ready & req_valid & {NUM_REQ{rst_n}};
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (seen[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                if (rq[i].size() > 0 && !paused[i]) begin
                    head               = rq[i][0];
                    req_valid[i]       = 1'b1;
                    req_last[i]        = head[8];
                    req_byte[i*8 +: 8] = head[7:0];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_last[i]        = 1'($urandom);
                    req_byte[i*8 +: 8] = 8'($urandom);
                end
            end
        end
    end

    // UART transmitter stand-in: busy for a few cycles per frame, then a done pulse.
    initial begin : transmitter
        bit dv_seen;
        int frame_left;
        frame_active = 1'b0;
        tx_done      = 1'b0;
        frame_left   = 0;
        forever begin
            @(negedge clk);
            dv_seen = tx_dv;
            @(posedge clk);
            #1;
            tx_done = 1'b0;
            if (frame_left > 0) begin
                frame_left--;
                if (frame_left == 0) begin
                    frame_active = 1'b0;
                    tx_done      = 1'b1;
                end
            end else if (dv_seen) begin
                frame_active = 1'b1;
                frame_left   = $urandom_range(1, 4);
            end else if (spurious_en && $urandom_range(0, 15) == 0) begin
                tx_done = 1'b1;
            end
        end
    end

    // Model: predict ready/dv/grant/busy each cycle, then advance on the coming edge.
    initial begin : model
        logic [NUM_REQ-1:0] exp_ready;
        logic [NUM_REQ-1:0] exp_grant;
        logic [NUM_REQ-1:0] xfer;
        bit                 found;
        int                 j;
        int                 idx;
        m_last = NUM_REQ - 1; m_owner = -1; m_age = 0;
        m_pending = 0; m_issued = 0; m_locked = 0; m_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                checkOutput("rst_ready", 32'(req_ready), 32'h0);
                checkOutput("rst_tx_dv", 32'(tx_dv), 32'h0);
                checkOutput("rst_grant", 32'(grant), 32'h0);
                checkOutput("rst_busy", 32'(busy), 32'h0);
                checkOutput("rst_tx_byte", 32'(tx_byte), 32'h0);
                m_last = NUM_REQ - 1; m_owner = -1; m_age = 0;
                m_pending = 0; m_issued = 0; m_locked = 0; m_byte = 8'h00;
                sb.delete();
            end else begin
                exp_ready = '0;
                if (!m_pending && !m_issued) begin
                    if (m_locked) begin
                        exp_ready[m_owner] = 1'b1;
                    end else begin
                        found = 0;
                        for (int k = 1; k <= NUM_REQ; k++) begin
                            j = (m_last + k) % NUM_REQ;
                            if (!found && req_valid[j]) begin
                                found        = 1;
                                exp_ready[j] = 1'b1;
                            end
                        end
                    end
                end
                exp_grant = '0;
                if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
                checkOutput("ready", 32'(req_ready), 32'(exp_ready));
                checkOutput("tx_dv", 32'(tx_dv), 32'(m_pending && !tx_active));
                checkOutput("grant", 32'(grant), 32'(exp_grant));
                checkOutput("busy", 32'(busy), 32'(m_pending || m_issued || m_locked));
                if (m_pending || m_issued) checkOutput("tx_byte_stable", 32'(tx_byte), 32'(m_byte));

                xfer = exp_ready & req_valid;
                if (m_pending) begin
                    if (!tx_active) begin
                        m_pending = 0;
                        m_issued  = 1;
                    end
                end else if (m_issued) begin
                    if (tx_done) begin
                        m_issued = 0;
                        if (m_locked) m_age = 0;
                        else m_owner = -1;
                    end
                end else if (xfer != '0) begin
                    idx = 0;
                    for (int k = 0; k < NUM_REQ; k++) if (xfer[k]) idx = k;
                    m_byte    = req_byte[idx*8 +: 8];
                    m_locked  = !req_last[idx];
                    m_owner   = idx;
                    m_last    = idx;
                    m_pending = 1;
                    sb.push_back('{data: m_byte, idx: idx});
                end else if (m_locked) begin
                    // Packet abandoned once it has sat LOCK_TIMEOUT cycles unserved.
                    if (m_age + 1 == LOCK_TIMEOUT) begin
                        m_locked = 0;
                        m_owner  = -1;
                    end else begin
                        m_age++;
                    end
                end
            end
        end
    end

    // Scoreboard monitor: every start pulse must match the oldest accepted byte.
    initial begin : monitor
        sb_t             exp;
        logic [NUM_REQ-1:0] exp_grant;
        forever begin
            @(negedge clk);
            if (rst_n && tx_dv) begin
                tx_log.push_back(tx_byte);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL tx_unexpected actual=%0h expected=none at %0t", tx_byte, $time);
                end else begin
                    exp       = sb.pop_front();
                    exp_grant = '0;
                    exp_grant[exp.idx] = 1'b1;
                    checkOutput("sb_tx_byte", 32'(tx_byte), 32'(exp.data));
                    checkOutput("sb_tx_grant", 32'(grant), 32'(exp_grant));
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        errors++;
        $display("[TB] FAIL watchdog actual=running expected=finished at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : main
        int n;
        ext_busy    = 1'b0;
        spurious_en = 0;
        paused      = '0;
        rst_n       = 1'b0;

        // Single byte straight out of reset.
        applyStimulus(0, 8'h41, 1'b1);
        nextCycle(3);
        rst_n = 1'b1;
        waitIdle("idle_first", 100);
        expectLog("first_byte", 1, 8'h41, 0, 0, 0, 0, 0);

        // Two contenders with single-byte packets alternate.
        tx_log.delete();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 8'hB0 + 8'(k), 1'b1);
            applyStimulus(3, 8'hD0 + 8'(k), 1'b1);
        end
        waitIdle("idle_rr", 300);
        expectLog("rr_order", 6, 8'hB0, 8'hD0, 8'hB1, 8'hD1, 8'hB2, 8'hD2);

        // A locked packet stays contiguous while another requester waits.
        tx_log.delete();
        applyStimulus(2, 8'h10, 1'b0);
        applyStimulus(2, 8'h11, 1'b0);
        applyStimulus(2, 8'h12, 1'b1);
        nextCycle(1);
        applyStimulus(0, 8'h55, 1'b1);
        waitIdle("idle_packet", 300);
        expectLog("packet", 4, 8'h10, 8'h11, 8'h12, 8'h55, 0, 0);

        // Transmitter busy at issue time: the pulse waits.
        tx_log.delete();
        ext_busy = 1'b1;
        applyStimulus(1, 8'h77, 1'b1);
        nextCycle(50);
        checkOutput("stall_no_dv", 32'(tx_log.size()), 32'h0);
        ext_busy = 1'b0;
        waitIdle("idle_stall", 100);
        expectLog("stall", 1, 8'h77, 0, 0, 0, 0, 0);

        // Abandoned packet: lock expires, then the waiting requester is served.
        tx_log.delete();
        applyStimulus(1, 8'hA5, 1'b0);
        nextCycle(3);
        applyStimulus(0, 8'h5A, 1'b1);
        waitIdle("idle_timeout", 300);
        expectLog("timeout", 2, 8'hA5, 8'h5A, 0, 0, 0, 0);

        // Reset while the first byte of a packet is on the wire.
        tx_log.delete();
        applyStimulus(2, 8'h01, 1'b0);
        applyStimulus(2, 8'h02, 1'b0);
        applyStimulus(2, 8'h03, 1'b1);
        n = 0;
        while (tx_log.size() == 0 && n < 50) begin
            nextCycle(1);
            n++;
        end
        if (tx_log.size() == 0) failBound("wait_first_dv");
        rst_n = 1'b0;
        rq[2].delete();
        nextCycle(3);
        rst_n = 1'b1;
        nextCycle(20);
        checkOutput("rst_abort_dv_count", 32'(tx_log.size()), 32'h1);
        waitIdle("idle_reset", 100);

        // Random traffic with pauses, stalls, stray done pulses and one reset.
        spurious_en = 1;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rq[i].size() == 0 && $urandom_range(0, 15) == 0) begin
                    n = $urandom_range(1, 3);
                    for (int b = 0; b < n; b++) applyStimulus(i, 8'($urandom), b == n - 1);
                end
                if ($urandom_range(0, 39) == 0) paused[i] = !paused[i];
            end
            ext_busy = ($urandom_range(0, 9) == 0);
            if (c == 700) rst_n = 1'b0;
            if (c == 702) rst_n = 1'b1;
            nextCycle(1);
        end
        paused      = '0;
        ext_busy    = 1'b0;
        spurious_en = 0;
        waitIdle("idle_final", 3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
